// File: rtl/timer_share_arbiter.sv
// Round-robin scheduler sharing one down-counting interval timer among NREQ requesters.
// Grant appears 1 cycle after the load edge; a requester waits (req held) until it wins arbitration.
module timer_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_req;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [NREQ-1:0]  win_oh;
  logic [WIDTH-1:0] win_len;

  // Two passes: indices above ptr first, then wrap to the low indices.
  always_comb begin
    arb_req = (state_q == DONE) ? (req & ~done_q) : req;
    win_vld = 1'b0;
    win_idx = ptr_q;
    win_oh  = '0;
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && arb_req[i] && (i > int'(ptr_q))) begin
        win_vld   = 1'b1;
        win_idx   = PW'(i);
        win_oh[i] = 1'b1;
        win_len   = len[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && arb_req[i] && (i <= int'(ptr_q))) begin
        win_vld   = 1'b1;
        win_idx   = PW'(i);
        win_oh[i] = 1'b1;
        win_len   = len[i*WIDTH +: WIDTH];
      end
    end
    if (win_len == '0) win_len = WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (win_vld) begin
          state_d = RUN;
          ptr_d   = win_idx;
          grant_d = win_oh;
          count_d = win_len;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        // grant_q is one-hot here, so it selects the owner's req bit.
        if ((req & grant_q) == '0) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (count_q <= WIDTH'(1)) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
          count_d = '0;
          busy_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench for timer_share_arbiter: per-cycle expected outputs are queued with the stimulus.
module tb_timer_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      count;
  logic                  busy;

  timer_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .done    (done),
    .count   (count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // One entry per cycle: outputs expected after the edge, then inputs for the following edge.
  typedef struct {
    string       tag;
    logic [3:0]  g;
    logic [3:0]  d;
    logic [7:0]  c;
    logic        b;
    logic [3:0]  nreq;
    logic [31:0] nlen;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] g, input logic [3:0] d,
                      input logic [7:0] c, input logic b, input logic [3:0] nreq,
                      input logic [31:0] nlen);
    exp_t e;
    e.tag = tag; e.g = g; e.d = d; e.c = c; e.b = b; e.nreq = nreq; e.nlen = nlen;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      chk({e.tag, ".grant"}, 32'(grant), 32'(e.g));
      chk({e.tag, ".done"},  32'(done),  32'(e.d));
      chk({e.tag, ".count"}, 32'(count), 32'(e.c));
      chk({e.tag, ".busy"},  32'(busy),  32'(e.b));
      req = e.nreq;
      len = e.nlen;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".done"},  32'(done),  32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  g;
    logic [31:0] l;
    reset_n = 1'b0;
    req     = '0;
    len     = '0;
    #2;
    chk_zero("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Round robin from reset: requester 0 first, no idle gaps.
    l   = {8'd2, 8'd2, 8'd2, 8'd2};
    len = l;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      push($sformatf("rr%0d_a", k), g, 4'b0, 8'd2, 1'b1, 4'b1111, l);
      push($sformatf("rr%0d_b", k), g, 4'b0, 8'd1, 1'b1, 4'b1111, l);
      push($sformatf("rr%0d_d", k), 4'b0, g, 8'd0, 1'b1, (k == 4) ? 4'b0000 : 4'b1111, l);
    end
    push("rr_idle", 4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    // Single request, length 3.
    l   = {8'd0, 8'd0, 8'd0, 8'd3};
    len = l;
    req = 4'b0001;
    push("s_3", 4'b0001, 4'b0, 8'd3, 1'b1, 4'b0001, l);
    push("s_2", 4'b0001, 4'b0, 8'd2, 1'b1, 4'b0001, l);
    push("s_1", 4'b0001, 4'b0, 8'd1, 1'b1, 4'b0001, l);
    push("s_d", 4'b0, 4'b0001, 8'd0, 1'b1, 4'b0000, l);
    push("s_i", 4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    // Zero length behaves as length 1.
    l   = {8'd0, 8'd0, 8'd0, 8'd0};
    len = l;
    req = 4'b0100;
    push("z_1", 4'b0100, 4'b0, 8'd1, 1'b1, 4'b0100, l);
    push("z_d", 4'b0, 4'b0100, 8'd0, 1'b1, 4'b0000, l);
    push("z_i", 4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    // Abort at count 4, then pointer wraps past requester 1 to requester 0.
    l   = {8'd0, 8'd0, 8'd8, 8'd2};
    len = l;
    req = 4'b0010;
    for (int k = 8; k >= 5; k--)
      push($sformatf("ab_%0d", k), 4'b0010, 4'b0, 8'(k), 1'b1, 4'b0010, l);
    push("ab_4",  4'b0010, 4'b0, 8'd4, 1'b1, 4'b0000, l);
    push("ab_x",  4'b0, 4'b0, 8'd0, 1'b0, 4'b0011, l);
    push("ab_g2", 4'b0001, 4'b0, 8'd2, 1'b1, 4'b0011, l);
    push("ab_g1", 4'b0001, 4'b0, 8'd1, 1'b1, 4'b0011, l);
    push("ab_d",  4'b0, 4'b0001, 8'd0, 1'b1, 4'b0000, l);
    push("ab_i",  4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    // len sampled at load only: 5 grant cycles despite change to 2.
    l   = {8'd0, 8'd0, 8'd0, 8'd5};
    len = l;
    req = 4'b0001;
    push("lc_5", 4'b0001, 4'b0, 8'd5, 1'b1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd2});
    l = {8'd0, 8'd0, 8'd0, 8'd2};
    for (int k = 4; k >= 1; k--)
      push($sformatf("lc_%0d", k), 4'b0001, 4'b0, 8'(k), 1'b1, 4'b0001, l);
    push("lc_d", 4'b0, 4'b0001, 8'd0, 1'b1, 4'b0000, l);
    push("lc_i", 4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    // Async reset while count=3, then release with req=1010.
    l   = {8'd0, 8'd0, 8'd0, 8'd6};
    len = l;
    req = 4'b0001;
    for (int k = 6; k >= 4; k--)
      push($sformatf("ar_%0d", k), 4'b0001, 4'b0, 8'(k), 1'b1, 4'b0001, l);
    drain();
    @(posedge clk); #1;
    chk("ar_3.count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("ar_async");
    l   = {8'd1, 8'd0, 8'd1, 8'd0};
    len = l;
    req = 4'b1010;
    @(posedge clk); #1;
    chk_zero("ar_held");
    reset_n = 1'b1;
    push("ar_g1",  4'b0010, 4'b0, 8'd1, 1'b1, 4'b1010, l);
    push("ar_d1",  4'b0, 4'b0010, 8'd0, 1'b1, 4'b1010, l);
    push("ar_g3",  4'b1000, 4'b0, 8'd1, 1'b1, 4'b1010, l);
    push("ar_d3",  4'b0, 4'b1000, 8'd0, 1'b1, 4'b0000, l);
    push("ar_i",   4'b0, 4'b0, 8'd0, 1'b0, 4'b0000, l);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_share_arbiter.md
# timer_share_arbiter

Shares one down-counting interval timer among NREQ requesters. Each requester asks for a delay of its own programmed length. The block grants the timer round-robin, counts the interval, and signals completion with a one-cycle done pulse. It sits beside the counter blocks as the scheduler that sequences timed intervals for several clients on a single counter datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of interval length and count
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester level request; held high until done or abort
- len  input  NREQ*WIDTH  interval length; requester i uses len[i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot owner of the running interval; 0 when not in RUN
- done  output  NREQ  one-hot, one-cycle completion pulse
- count  output  WIDTH  cycles remaining in the current interval
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- All outputs are registered.
- Reset, asynchronous, while reset_n=0:
  - state=IDLE; grant=0, done=0, count=0, busy=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has highest priority first.
- Arbitration:
  - Search req starting at index ptr+1 and wrap.
  - The first set bit wins; ptr becomes the winner's index when it is loaded.
- IDLE:
  - If any req bit is set, load the winner w: state=RUN, grant=1<<w, count=len_w, busy=1.
  - len_w=0 is treated as 1.
- RUN, with req[w] still high:
  - If count>1: count decrements by 1.
  - If count==1: state=DONE, grant=0, done=1<<w, count=0.
- RUN abort: if req[w] is low at the edge, state=IDLE, grant=0, count=0, no done pulse. ptr keeps w.
- DONE:
  - done is high for exactly this one cycle.
  - Arbitrate with req[w] masked off. If another request wins, load it as in IDLE (back-to-back). Otherwise go to IDLE.
- len is sampled only at load. Changes to len during RUN are ignored.
- A requester that keeps req high after its done pulse is re-granted through normal arbitration. To release, it must drop req by the edge that ends the DONE cycle.

## Timing
- Load edge: the edge at which req is sampled high in IDLE.
  - grant, busy and count=L are visible in the cycle after this edge.
  - Latency from req rising to grant is 1 cycle.
- grant is high for exactly L cycles, with count showing L, L-1, ..., 1.
- done is high in cycle L+1, with count=0.
- Back-to-back: the next requester's grant starts in cycle L+2.
- Cycles per interval while contended: L+1.
- busy is low only in IDLE. It stays high through DONE into the next RUN.
- Multiple simultaneous req rises: one winner per load edge; the others wait in rotation.
- Reset asserted mid-RUN: all outputs clear immediately, without waiting for clk. No done pulse.
- Reset release: the first load goes to the lowest-index active requester.
- count arithmetic is unsigned WIDTH bits. It never underflows; the RUN exit occurs at count==1.

## Test plan
- Single request: req=0001, len0=3.
  - grant=0001 for 3 cycles, count 3,2,1.
  - Then done=0001 for 1 cycle with count=0, then IDLE with busy=0.
- Round robin: req=1111 held, all len=2.
  - Grants in order 0001,0010,0100,1000,0001.
  - Each grant lasts 2 cycles, followed by 1 done cycle; no idle gap between intervals.
- Zero length: req=0100, len2=0.
  - grant=0100 for 1 cycle with count=1.
  - Next cycle done=0100.
- Abort: req=0010, len1=8; req1 dropped while count=4.
  - Next cycle grant=0, count=0, busy=0, no done pulse.
  - A following req=0011 grants requester 0 (pointer wraps past 1).
- Async reset mid-run: len0=6; pull reset_n low while count=3, off the clock edge.
  - grant, done, count and busy read 0 before the next edge.
  - After release with req=1010, requester 1 is granted first.
- len change mid-run: len0=5 at load, changed to 2 during RUN.
  - The interval still lasts 5 grant cycles, with done in the 6th.
